// File: rtl/acl_spi_responder.sv
// acl_spi_responder: oversampled SPI-slave emulation of the ADXL362 register interface.
// Every SPI pin is synchronised into i_clk; SCLK and CSN edges are detected in the
// i_clk domain, so the master must hold SCLK high and low for at least 8 i_clk cycles.
// Transfers are command byte (0x0A write, 0x0B read), address byte, then any number of
// data bytes with an auto-incrementing 8-bit pointer. All reads in one CS frame use one
// snapshot of the tilt sample.
module acl_spi_responder #(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PART_ID     = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_csn,
    output logic        o_miso,
    input  logic [11:0] i_accel_x,
    input  logic [11:0] i_accel_y,
    input  logic [11:0] i_accel_z,
    input  logic        i_sample_valid,
    output logic [7:0]  o_power_ctl,
    output logic        o_measuring,
    output logic        o_wr_strobe,
    output logic [7:0]  o_wr_addr,
    output logic [7:0]  o_wr_data
);
    localparam logic [7:0] CMD_WRITE    = 8'h0A;
    localparam logic [7:0] CMD_READ     = 8'h0B;
    localparam logic [7:0] FILTER_RST   = 8'h13;
    localparam logic [7:0] SOFT_RST_KEY = 8'h52;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

    // The extra top flop of SCLK/CSN keeps the previous synchronised value for edge detection.
    logic [SYNC_STAGES:0]   r_sclk_sync;
    logic [SYNC_STAGES:0]   r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic [11:0] r_live_x, r_live_y, r_live_z;
    logic [11:0] r_snap_x, r_snap_y, r_snap_z;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_ptr;
    logic        r_is_read;
    logic [7:0]  r_tx_shift;
    logic        r_miso;
    logic        r_wr_strobe;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_filter_ctl;
    logic [7:0]  r_power_ctl;
    logic        r_data_ready;
    logic        r_soft_rst_pend;   // 0x52 written to SOFT_RESET during this frame
    logic        r_status_rd;       // STATUS was loaded for the master during this frame

    logic        w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_mosi, w_byte_done;
    logic [7:0]  w_shift_next, w_ptr_inc, w_rd_addr, w_rd_data;

    // Upper byte of a 12-bit two's-complement sample, sign-extended to 8 bits.
    function automatic logic [7:0] f_hi(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

    // Synchronise the asynchronous SPI pins into i_clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], i_sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-1:0], i_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign w_sclk_rise  = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
    assign w_sclk_fall  = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
    assign w_csn_rise   = r_csn_sync[SYNC_STAGES-1] & ~r_csn_sync[SYNC_STAGES];
    assign w_csn_fall   = ~r_csn_sync[SYNC_STAGES-1] & r_csn_sync[SYNC_STAGES];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_shift_next = {r_shift, w_mosi};
    assign w_byte_done  = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_ptr_inc    = r_ptr + 8'd1;
    // The address byte selects the first read byte; afterwards the next byte is prefetched at ptr+1.
    assign w_rd_addr    = (r_state == S_ADDR) ? w_shift_next : w_ptr_inc;

    // Live sample registers follow the strobe; the snapshot is frozen for the whole CS frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live_x <= '0; r_live_y <= '0; r_live_z <= '0;
            r_snap_x <= '0; r_snap_y <= '0; r_snap_z <= '0;
        end else begin
            if (i_sample_valid) begin
                r_live_x <= i_accel_x; r_live_y <= i_accel_y; r_live_z <= i_accel_z;
            end
            if (w_csn_fall) begin
                r_snap_x <= i_sample_valid ? i_accel_x : r_live_x;
                r_snap_y <= i_sample_valid ? i_accel_y : r_live_y;
                r_snap_z <= i_sample_valid ? i_accel_z : r_live_z;
            end
        end
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            8'h00:   w_rd_data = DEVID_AD;
            8'h01:   w_rd_data = DEVID_MST;
            8'h02:   w_rd_data = PART_ID;
            8'h03:   w_rd_data = 8'h02;
            8'h08:   w_rd_data = r_snap_x[11:4];
            8'h09:   w_rd_data = r_snap_y[11:4];
            8'h0A:   w_rd_data = r_snap_z[11:4];
            8'h0B:   w_rd_data = {7'b0, r_data_ready};
            8'h0E:   w_rd_data = r_snap_x[7:0];
            8'h0F:   w_rd_data = f_hi(r_snap_x);
            8'h10:   w_rd_data = r_snap_y[7:0];
            8'h11:   w_rd_data = f_hi(r_snap_y);
            8'h12:   w_rd_data = r_snap_z[7:0];
            8'h13:   w_rd_data = f_hi(r_snap_z);
            8'h2C:   w_rd_data = r_filter_ctl;
            8'h2D:   w_rd_data = r_power_ctl;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Transfer FSM: byte assembly, command decode, register writes and MISO shifting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_ptr           <= '0;
            r_is_read       <= 1'b0;
            r_tx_shift      <= '0;
            r_miso          <= 1'b0;
            r_wr_strobe     <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_filter_ctl    <= FILTER_RST;
            r_power_ctl     <= '0;
            r_data_ready    <= 1'b0;
            r_soft_rst_pend <= 1'b0;
            r_status_rd     <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_csn_rise) begin
                // Frame end: a partial byte is dropped, pending soft reset takes effect.
                r_state         <= S_IDLE;
                r_bit_cnt       <= '0;
                r_miso          <= 1'b0;
                r_soft_rst_pend <= 1'b0;
                r_status_rd     <= 1'b0;
                if (r_soft_rst_pend) begin
                    r_filter_ctl <= FILTER_RST;
                    r_power_ctl  <= '0;
                end
            end else if (w_csn_fall) begin
                r_state   <= S_CMD;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else if (r_state != S_IDLE && w_sclk_rise) begin
                r_shift   <= w_shift_next[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_is_read <= (w_shift_next == CMD_READ);
                            if (w_shift_next == CMD_WRITE || w_shift_next == CMD_READ)
                                r_state <= S_ADDR;
                            else
                                r_state <= S_IGNORE;
                        end
                        S_ADDR: begin
                            r_ptr   <= w_shift_next;
                            r_state <= S_DATA;
                            if (r_is_read) begin
                                r_tx_shift <= w_rd_data;
                                r_miso     <= w_rd_data[7];
                                if (w_rd_addr == 8'h0B) r_status_rd <= 1'b1;
                            end
                        end
                        S_DATA: begin
                            r_ptr <= w_ptr_inc;
                            if (r_is_read) begin
                                r_tx_shift <= w_rd_data;
                                r_miso     <= w_rd_data[7];
                                if (w_rd_addr == 8'h0B) r_status_rd <= 1'b1;
                            end else begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_ptr;
                                r_wr_data   <= w_shift_next;
                                if (r_ptr == 8'h2C) r_filter_ctl <= w_shift_next;
                                if (r_ptr == 8'h2D) r_power_ctl <= w_shift_next;
                                if (r_ptr == 8'h1F && w_shift_next == SOFT_RST_KEY)
                                    r_soft_rst_pend <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (r_state == S_DATA && r_is_read && w_sclk_fall && r_bit_cnt != 3'd0) begin
                // No shift on the fall after the 8th bit: the reload already presented the next MSB.
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_miso     <= r_tx_shift[6];
            end
            // A new sample outranks the end-of-frame clear.
            if (i_sample_valid)
                r_data_ready <= 1'b1;
            else if (w_csn_rise && (r_status_rd || r_soft_rst_pend))
                r_data_ready <= 1'b0;
        end
    end

    assign o_miso      = r_miso;
    assign o_power_ctl = r_power_ctl;
    assign o_measuring = (r_power_ctl[1:0] == 2'b10);
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;

endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: drives an SPI mode-0 master against acl_spi_responder and checks
// read data, write strobes and control outputs against a register-map model.
module tb_acl_spi_responder;
    localparam int HALF = 10;  // SCLK half period in i_clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        csn = 1'b1;
    logic        miso;
    logic [11:0] ax = '0, ay = '0, az = '0;
    logic        sv = 1'b0;
    logic [7:0]  power_ctl;
    logic        measuring;
    logic        wr_strobe;
    logic [7:0]  wr_addr, wr_data;

    // clock / reset
    always #5 clk = ~clk;

    acl_spi_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_mosi(mosi), .i_csn(csn),
        .o_miso(miso), .i_accel_x(ax), .i_accel_y(ay), .i_accel_z(az),
        .i_sample_valid(sv), .o_power_ctl(power_ctl), .o_measuring(measuring),
        .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: expected and observed write strobes {addr, data}
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    // per-frame received bytes and model expectations for read data
    logic [7:0]  rx_q[$];
    logic [7:0]  rd_exp_q[$];
    logic [7:0]  wr_buf[4];

    // register-map model
    logic [11:0] m_live[3];
    logic [11:0] m_snap[3];
    logic [7:0]  m_filter, m_power;
    bit          m_dr, m_srst, m_rdst;

    always @(negedge clk) if (wr_strobe) got_q.push_back({wr_addr, wr_data});

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic signed [15:0] w;
        int k;
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h01) return 8'h1D;
        if (a == 8'h02) return 8'hF2;
        if (a == 8'h03) return 8'h02;
        if (a >= 8'h08 && a <= 8'h0A) begin
            k = int'(a) - 8;
            return 8'(m_snap[k] >> 4);
        end
        if (a == 8'h0B) return m_dr ? 8'h01 : 8'h00;
        if (a >= 8'h0E && a <= 8'h13) begin
            k = (int'(a) - 14) / 2;
            w = 16'($signed(m_snap[k]));
            return a[0] ? w[15:8] : w[7:0];
        end
        if (a == 8'h2C) return m_filter;
        if (a == 8'h2D) return m_power;
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_live[i] = '0; m_snap[i] = '0; end
        m_filter = 8'h13; m_power = 8'h00; m_dr = 0; m_srst = 0; m_rdst = 0;
    endtask

    // driver tasks
    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] b;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            clk_wait(HALF);
            b[i] = miso;
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
        end
        rx = b;
    endtask

    task automatic cs_low();
        csn = 1'b0;
        for (int i = 0; i < 3; i++) m_snap[i] = m_live[i];
        clk_wait(HALF);
    endtask

    task automatic cs_high();
        clk_wait(HALF);
        csn = 1'b1;
        clk_wait(HALF);
        if (m_srst) begin m_filter = 8'h13; m_power = 8'h00; m_dr = 0; end
        if (m_rdst) m_dr = 0;
        m_srst = 0; m_rdst = 0;
    endtask

    task automatic sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        ax = x; ay = y; az = z; sv = 1'b1;
        clk_wait(1);
        sv = 1'b0;
        m_live[0] = x; m_live[1] = y; m_live[2] = z; m_dr = 1;
        clk_wait(2);
    endtask

    task automatic read_frame(input logic [7:0] a, input int n);
        logic [7:0] r;
        rx_q.delete(); rd_exp_q.delete();
        cs_low();
        spi_byte(8'h0B, r);
        spi_byte(a, r);
        for (int i = 0; i < n; i++) begin
            rd_exp_q.push_back(m_read(8'(a + i)));
            if (8'(a + i) == 8'h0B) m_rdst = 1;
            spi_byte(8'h00, r);
            rx_q.push_back(r);
        end
        cs_high();
    endtask

    task automatic write_frame(input logic [7:0] a, input int n);
        logic [7:0] r;
        logic [7:0] ad;
        rx_q.delete();
        cs_low();
        spi_byte(8'h0A, r); rx_q.push_back(r);
        spi_byte(a, r);     rx_q.push_back(r);
        for (int i = 0; i < n; i++) begin
            ad = 8'(a + i);
            spi_byte(wr_buf[i], r); rx_q.push_back(r);
            exp_q.push_back({ad, wr_buf[i]});
            if (ad == 8'h2C) m_filter = wr_buf[i];
            if (ad == 8'h2D) m_power = wr_buf[i];
            if (ad == 8'h1F && wr_buf[i] == 8'h52) m_srst = 1;
        end
        cs_high();
    endtask

    // tests
    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        clk_wait(5);
        n_tests++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
        n_tests++; if (power_ctl !== 8'h00) begin n_fail++; $display("FAIL reset_power_ctl got=%h exp=00", power_ctl); end
        n_tests++; if (measuring !== 1'b0) begin n_fail++; $display("FAIL reset_measuring got=%b exp=0", measuring); end
        n_tests++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
        n_tests++; if ({wr_addr, wr_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_addr_data got=%h exp=0000", {wr_addr, wr_data}); end
        rst_n = 1'b1;
        clk_wait(5);
    endtask

    task automatic test_read_id();
        read_frame(8'h00, 4);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== rd_exp_q[i]) begin n_fail++; $display("FAIL read_id byte%0d got=%h exp=%h", i, rx_q[i], rd_exp_q[i]); end
        end
        read_frame(8'h2C, 1);
        n_tests++; if (rx_q[0] !== 8'h13) begin n_fail++; $display("FAIL filter_ctl_reset got=%h exp=13", rx_q[0]); end
    endtask

    task automatic test_burst_xy();
        sample(12'hF85, 12'h07A, 12'($urandom_range(0, 4095)));
        read_frame(8'h0E, 6);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (rx_q[i] !== rd_exp_q[i]) begin n_fail++; $display("FAIL burst_xyz byte%0d got=%h exp=%h", i, rx_q[i], rd_exp_q[i]); end
        end
        read_frame(8'h08, 2);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rx_q[i] !== rd_exp_q[i]) begin n_fail++; $display("FAIL burst_data8 byte%0d got=%h exp=%h", i, rx_q[i], rd_exp_q[i]); end
        end
    endtask

    task automatic test_write_power();
        exp_q.delete(); got_q.delete();
        wr_buf[0] = 8'h02;
        write_frame(8'h2D, 1);
        n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL wr_power_strobe_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() == 1) begin
            n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL wr_power_strobe got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        n_tests++; if (power_ctl !== m_power) begin n_fail++; $display("FAIL wr_power_ctl got=%h exp=%h", power_ctl, m_power); end
        n_tests++; if (measuring !== 1'b1) begin n_fail++; $display("FAIL wr_measuring got=%b exp=1", measuring); end
        n_tests++; if (rx_q[2] !== 8'h00) begin n_fail++; $display("FAIL wr_miso_quiet got=%h exp=00", rx_q[2]); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_snapshot();
        logic [7:0] r;
        logic [7:0] e0, e1;
        rx_q.delete();
        cs_low();
        e0 = m_read(8'h0E); e1 = m_read(8'h0F);
        spi_byte(8'h0B, r);
        spi_byte(8'h0E, r);
        sample(12'h123, m_live[1], m_live[2]);
        spi_byte(8'h00, r); rx_q.push_back(r);
        spi_byte(8'h00, r); rx_q.push_back(r);
        cs_high();
        n_tests++; if (rx_q[0] !== e0) begin n_fail++; $display("FAIL snapshot_old_lo got=%h exp=%h", rx_q[0], e0); end
        n_tests++; if (rx_q[1] !== e1) begin n_fail++; $display("FAIL snapshot_old_hi got=%h exp=%h", rx_q[1], e1); end
        read_frame(8'h0E, 2);
        n_tests++; if (rx_q[0] !== 8'h23) begin n_fail++; $display("FAIL snapshot_new_lo got=%h exp=23", rx_q[0]); end
        n_tests++; if (rx_q[1] !== rd_exp_q[1]) begin n_fail++; $display("FAIL snapshot_new_hi got=%h exp=%h", rx_q[1], rd_exp_q[1]); end
    endtask

    task automatic test_illegal_abort();
        logic [7:0] r;
        logic [7:0] acc;
        exp_q.delete(); got_q.delete();
        acc = '0;
        cs_low();
        spi_byte(8'h0D, r); acc |= r;
        spi_byte(8'h00, r); acc |= r;
        spi_byte(8'h00, r); acc |= r;
        cs_high();
        n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL illegal_cmd_miso got=%h exp=00", acc); end
        // write 0x2D, abandon after four data bits
        cs_low();
        spi_byte(8'h0A, r);
        spi_byte(8'h2D, r);
        for (int i = 7; i >= 4; i--) begin
            mosi = 1'b1;
            clk_wait(HALF);
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
        end
        cs_high();
        n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL abort_strobe_count got=%0d exp=0", got_q.size()); end
        n_tests++; if (power_ctl !== m_power) begin n_fail++; $display("FAIL abort_power_ctl got=%h exp=%h", power_ctl, m_power); end
        got_q.delete();
    endtask

    task automatic test_status_soft_reset();
        sample(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        read_frame(8'h0B, 1);
        n_tests++; if (rx_q[0] !== 8'h01) begin n_fail++; $display("FAIL status_set got=%h exp=01", rx_q[0]); end
        read_frame(8'h0B, 1);
        n_tests++; if (rx_q[0] !== rd_exp_q[0]) begin n_fail++; $display("FAIL status_cleared got=%h exp=%h", rx_q[0], rd_exp_q[0]); end
        exp_q.delete(); got_q.delete();
        wr_buf[0] = 8'h55; wr_buf[1] = 8'h0A;
        write_frame(8'h2C, 2);
        wr_buf[0] = 8'h33;
        write_frame(8'h1F, 1);
        n_tests++; if (power_ctl !== 8'h0A) begin n_fail++; $display("FAIL soft_reset_wrong_key got=%h exp=0a", power_ctl); end
        sample(12'h7FF, 12'h800, 12'h001);
        wr_buf[0] = 8'h52;
        write_frame(8'h1F, 1);
        n_tests++; if (power_ctl !== 8'h00) begin n_fail++; $display("FAIL soft_reset_power got=%h exp=00", power_ctl); end
        read_frame(8'h2C, 1);
        n_tests++; if (rx_q[0] !== m_filter) begin n_fail++; $display("FAIL soft_reset_filter got=%h exp=%h", rx_q[0], m_filter); end
        n_tests++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL soft_reset_strobe_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL soft_reset_strobe%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] rd_addrs[13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h0E, 8'h0F,
                                     8'h10, 8'h12, 8'h2C, 8'h2D, 8'hFE, 8'h40};
        logic [7:0] wr_addrs[5] = '{8'h2C, 8'h2D, 8'h1F, 8'h30, 8'h05};
        logic [7:0] a;
        int n;
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 1) == 1)
                sample(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            if ($urandom_range(0, 1) == 1) begin
                a = rd_addrs[$urandom_range(0, 12)];
                n = $urandom_range(1, 4);
                if (8'(a + n) == 8'h0B) n = n + 1;
                read_frame(a, n);
                for (int i = 0; i < n; i++) begin
                    n_tests++;
                    if (rx_q[i] !== rd_exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand_read f%0d addr=%h byte%0d got=%h exp=%h", f, a, i, rx_q[i], rd_exp_q[i]);
                    end
                end
            end else begin
                exp_q.delete(); got_q.delete();
                a = wr_addrs[$urandom_range(0, 4)];
                n = $urandom_range(1, 2);
                for (int i = 0; i < n; i++) begin
                    wr_buf[i] = 8'($urandom_range(0, 255));
                    if (8'(a + i) == 8'h1F && $urandom_range(0, 3) == 0) wr_buf[i] = 8'h52;
                end
                write_frame(a, n);
                n_tests++;
                if (got_q.size() !== exp_q.size()) begin
                    n_fail++;
                    $display("FAIL rand_strobe_count f%0d got=%0d exp=%0d", f, got_q.size(), exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                    n_tests++;
                    if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_strobe f%0d #%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
                end
                n_tests++;
                if (power_ctl !== m_power || measuring !== (m_power[1:0] == 2'b10)) begin
                    n_fail++;
                    $display("FAIL rand_power f%0d got=%h/%b exp=%h", f, power_ctl, measuring, m_power);
                end
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] r;
        read_frame(8'hFF, 2);
        n_tests++; if (rx_q[0] !== 8'h00) begin n_fail++; $display("FAIL wrap_byte0 got=%h exp=00", rx_q[0]); end
        n_tests++; if (rx_q[1] !== 8'hAD) begin n_fail++; $display("FAIL wrap_byte1 got=%h exp=ad", rx_q[1]); end
        wr_buf[0] = 8'h02;
        write_frame(8'h2D, 1);
        cs_low();
        spi_byte(8'h0B, r);
        spi_byte(8'h00, r);
        clk_wait(4);
        n_tests++; if (miso !== 1'b1) begin n_fail++; $display("FAIL midread_miso_msb got=%b exp=1", miso); end
        rst_n = 1'b0;
        #2;
        n_tests++; if (miso !== 1'b0) begin n_fail++; $display("FAIL async_reset_miso got=%b exp=0", miso); end
        n_tests++; if (power_ctl !== 8'h00) begin n_fail++; $display("FAIL async_reset_power got=%h exp=00", power_ctl); end
        csn = 1'b1;
        clk_wait(4);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete(); got_q.delete();
        clk_wait(HALF);
        read_frame(8'h2C, 2);
        n_tests++; if (rx_q[0] !== 8'h13 || rx_q[1] !== 8'h00) begin n_fail++; $display("FAIL after_reset_regs got=%h%h exp=1300", rx_q[0], rx_q[1]); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_burst_xy();
        test_write_power();
        test_snapshot();
        test_illegal_abort();
        test_status_soft_reset();
        test_random();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
